// File: rtl/serial_addsub_2b.sv
// Multi-cycle WIDTH-bit adder/subtractor: one 2-bit ripple slice per cycle, LSB first,
// with the slice carry registered between cycles and a start/done handshake.
module serial_addsub_2b #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned N     = WIDTH / 2;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IDX_W = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  logic             accept_c;
  logic             last_c;
  logic             c1_c;
  logic             c2_c;
  logic [1:0]       sum_c;
  logic [IDX_W-1:0] idx_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_c   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_c) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // a start here restarts immediately without passing through IDLE
        if (start) begin
          accept_c   = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // 2-bit ripple slice on the low bits of the shifting operand registers
  always_comb begin
    last_c   = (cnt == CNT_W'(N - 1));
    idx_c    = {cnt, 1'b0};
    sum_c[0] = op_a[0] ^ op_b[0] ^ carry;
    c1_c     = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
    sum_c[1] = op_a[1] ^ op_b[1] ^ c1_c;
    c2_c     = (op_a[1] & op_b[1]) | (c1_c & (op_a[1] ^ op_b[1]));
  end

  assign busy  = (state == RUN);
  assign ready = (state != RUN);
  assign done  = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept_c) begin
      cnt   <= '0;
      carry <= op_sub;
      op_a  <= data_a;
      op_b  <= op_sub ? ~data_b : data_b;
    end else if (state == RUN) begin
      result[idx_c +: 2] <= sum_c;
      carry              <= c2_c;
      cnt                <= cnt + CNT_W'(1);
      op_a               <= op_a >> 2;
      op_b               <= op_b >> 2;
      if (last_c) begin
        carry_out <= c2_c;
        overflow  <= c1_c ^ c2_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_2b.sv
// Self-checking bench for serial_addsub_2b: directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_serial_addsub_2b;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op_sub;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;

  int checks;
  int errors;

  serial_addsub_2b #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op_sub    (op_sub),
    .data_a    (data_a),
    .data_b    (data_b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: {overflow, carry_out, result} from plain wide arithmetic
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [31:0] bb;
    logic [32:0] s;
    logic        ov;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {32'd0, sub};
    ov = (a[31] == bb[31]) && (s[31] != a[31]);
    return {ov, s[32], s[31:0]};
  endfunction

  // Drives start for one edge (E0) then counts edges until done is seen
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       output int cyc, output logic busy_after);
    data_a = a;
    data_b = b;
    op_sub = sub;
    start  = 1'b1;
    @(posedge clock); #1;
    start      = 1'b0;
    busy_after = busy;
    data_a     = $urandom;
    data_b     = $urandom;
    op_sub     = 1'($urandom);
    cyc        = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: got rdy/busy/done=%b required 100", {ready, busy, done});
    end
    checks++;
    if ({overflow, carry_out, result} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ov=%b co=%b r=%h required all zero", overflow, carry_out, result);
    end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [5] = '{32'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
    logic [31:0] tb [5] = '{32'd3, 32'd1, 32'd1, 32'd7, 32'd1};
    logic        ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] er [5] = '{32'd8, 32'h8000_0000, 32'd0, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
    logic        ec [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        eo [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int   cyc;
    logic ba;
    for (int i = 0; i < 5; i++) begin
      issue(ta[i], tb[i], ts[i], cyc, ba);
      checks++;
      if (cyc != 16 || ba !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d edges busy=%b required 16 edges busy=1", i, cyc, ba);
      end
      checks++;
      if (result !== er[i] || carry_out !== ec[i] || overflow !== eo[i]) begin
        errors++;
        $display("FAIL dir%0d_value: got r=%h co=%b ov=%b required r=%h co=%b ov=%b",
                 i, result, carry_out, overflow, er[i], ec[i], eo[i]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_hold();
    logic [31:0] r0;
    int   cyc;
    logic ba;
    issue(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, cyc, ba);
    r0 = result;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (result !== 32'hDEAD_BEEF || r0 !== 32'hDEAD_BEEF || {ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL hold_idle: got r=%h (at done %h) rdy/busy/done=%b required r=deadbeef flags 100",
               result, r0, {ready, busy, done});
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    logic ba;
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, cyc, ba);
    checks++;
    if (result !== 32'd0 || carry_out !== 1'b1 || overflow !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: got r=%h co=%b ov=%b rdy=%b required r=0 co=1 ov=0 rdy=1",
               result, carry_out, overflow, ready);
    end
    issue(32'd2, 32'd2, 1'b0, cyc, ba);
    checks++;
    if (ba !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy: got busy=%b after DONE-cycle start required 1", ba);
    end
    checks++;
    if (cyc != 16 || result !== 32'd4 || carry_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got %0d edges r=%h co=%b required 16 edges r=4 co=0", cyc, result, carry_out);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_ignore_start();
    int cyc;
    data_a = 32'd1;
    data_b = 32'd1;
    op_sub = 1'b0;
    start  = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc   = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (cyc == 5) begin
        start  = 1'b1;
        data_a = 32'hFFFF;
        data_b = 32'hFFFF;
        op_sub = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (cyc != 16 || result !== 32'd2) begin
      errors++;
      $display("FAIL ignore_start: got %0d edges r=%h required 16 edges r=2", cyc, result);
    end
    @(posedge clock); #1;
    checks++;
    if ({ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL ignore_not_queued: got rdy/busy/done=%b required 100", {ready, busy, done});
    end
  endtask

  task automatic test_reset_mid_run();
    int   seen;
    int   cyc;
    logic ba;
    data_a = 32'h1234_5678;
    data_b = 32'd1;
    op_sub = 1'b0;
    start  = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if (result !== 32'd0 || {ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid_run: got r=%h rdy/busy/done=%b required r=0 flags 100",
               result, {ready, busy, done});
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d done pulses required 0", seen);
    end
    issue(32'h1234_5678, 32'd1, 1'b1, cyc, ba);
    checks++;
    if (cyc != 16 || result !== 32'h1234_5677 || carry_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_recover: got %0d edges r=%h co=%b required 16 edges r=12345677 co=1",
               cyc, result, carry_out);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [33:0] exp;
    int          cyc;
    logic        ba;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       begin a = 32'h8000_0000 | $urandom; b = 32'h8000_0000 | $urandom; end
        1:       begin a = 32'h7FFF_FFFF & $urandom; b = 32'h7FFF_FFFF & $urandom; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      s   = 1'($urandom);
      exp = model(a, b, s);
      issue(a, b, s, cyc, ba);
      checks++;
      if (cyc != 16 || {overflow, carry_out, result} !== exp) begin
        errors++;
        $display("FAIL rand%0d: a=%h b=%h sub=%b got %0d edges ov=%b co=%b r=%h required 16 edges ov=%b co=%b r=%h",
                 i, a, b, s, cyc, overflow, carry_out, result, exp[33], exp[32], exp[31:0]);
      end
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    op_sub = 1'b0;
    data_a = '0;
    data_b = '0;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
